// File: rtl/cmul_ctrl_if.sv
// cmul_ctrl_if: upstream accept and downstream result handshakes
// for the complex-multiplier controller.
interface cmul_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic conj_b;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output conj_b,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  conj_b,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/cmul_ctrl.sv
// cmul_ctrl: steps datapath_mul through a 5-step complex multiply.
// Control outputs are Moore decodes of the state and conj flag.
module cmul_ctrl #(
  parameter int CNT_W     = 16,
  parameter int ALLOW_B2B = 1
) (
  input  logic             clk,
  input  logic             reset,
  cmul_ctrl_if.slave       hs,
  output logic             a_sel,
  output logic             b_sel,
  output logic             pp1_ce,
  output logic             pp2_ce,
  output logic             sub,
  output logic             p_r_ce,
  output logic             p_i_ce,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_RR = 3'd1,
    MUL_II = 3'd2,
    MUL_X1 = 3'd3,
    MUL_X2 = 3'd4,
    SUM_I  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic             cf_q, cf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_rdy;
  logic             accept;

  assign in_rdy = (state_q == IDLE) ||
                  ((ALLOW_B2B != 0) &&
                   (state_q == DONE) &&
                   hs.out_ready);
  assign accept       = hs.in_valid && in_rdy;
  assign hs.in_ready  = in_rdy;
  assign hs.out_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE) &&
                        (state_q != DONE);
  assign op_count     = cnt_q;

  // state, conj flag and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
    end
  end

  // schedule sequencing, result consume and accept
  always_comb begin
    state_d = state_q;
    cf_d    = cf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (accept) state_d = MUL_RR;
      MUL_RR: state_d = MUL_II;
      MUL_II: state_d = MUL_X1;
      MUL_X1: state_d = MUL_X2;
      MUL_X2: state_d = SUM_I;
      SUM_I:  state_d = DONE;
      DONE: begin
        if (hs.out_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = accept ? MUL_RR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) cf_d = hs.conj_b;
  end

  // datapath control decode; cf swaps the cross terms and sign
  always_comb begin
    a_sel  = 1'b0;
    b_sel  = 1'b0;
    pp1_ce = 1'b0;
    pp2_ce = 1'b0;
    sub    = 1'b0;
    p_r_ce = 1'b0;
    p_i_ce = 1'b0;
    case (state_q)
      MUL_RR: pp1_ce = 1'b1;
      MUL_II: begin
        a_sel  = 1'b1;
        b_sel  = 1'b1;
        pp2_ce = 1'b1;
      end
      MUL_X1: begin
        a_sel  = cf_q;
        b_sel  = !cf_q;
        pp1_ce = 1'b1;
        sub    = !cf_q;
        p_r_ce = 1'b1;
      end
      MUL_X2: begin
        a_sel  = !cf_q;
        b_sel  = cf_q;
        pp2_ce = 1'b1;
      end
      SUM_I: begin
        sub    = cf_q;
        p_i_ce = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cmul_ctrl.sv
// tb_cmul_ctrl: controller plus a behavioural datapath, checked
// against complex arithmetic and the per-state control table.
module tb_cmul_ctrl;

  typedef struct packed {
    logic a_sel;
    logic b_sel;
    logic pp1;
    logic pp2;
    logic sub;
    logic prce;
    logic pice;
    logic busy;
    logic ov;
  } ctl_t;

  typedef struct {
    logic [15:0] ar, ai, br, bi;
    bit          cj;
    logic [31:0] epr, epi;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sel;
  logic in_valid, conj_b, out_ready;
  logic in_ready, out_valid;

  cmul_ctrl_if if0 ();
  cmul_ctrl_if if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.conj_b    = conj_b;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.conj_b    = conj_b;
  assign if1.out_ready = out_ready;

  logic [6:0]  ce0, ce1, ctl;
  logic        busy0, busy1, busy_o;
  logic [15:0] cnt0, obs_cnt;
  logic [1:0]  cnt1;
  logic        rst0, rst1;

  assign rst0 = reset | sel;
  assign rst1 = reset | ~sel;

  cmul_ctrl dut0 (
    .clk      (clk),
    .reset    (rst0),
    .hs       (if0),
    .a_sel    (ce0[6]),
    .b_sel    (ce0[5]),
    .pp1_ce   (ce0[4]),
    .pp2_ce   (ce0[3]),
    .sub      (ce0[2]),
    .p_r_ce   (ce0[1]),
    .p_i_ce   (ce0[0]),
    .busy     (busy0),
    .op_count (cnt0)
  );

  cmul_ctrl #(.CNT_W(2), .ALLOW_B2B(0)) dut1 (
    .clk      (clk),
    .reset    (rst1),
    .hs       (if1),
    .a_sel    (ce1[6]),
    .b_sel    (ce1[5]),
    .pp1_ce   (ce1[4]),
    .pp2_ce   (ce1[3]),
    .sub      (ce1[2]),
    .p_r_ce   (ce1[1]),
    .p_i_ce   (ce1[0]),
    .busy     (busy1),
    .op_count (cnt1)
  );

  assign ctl       = sel ? ce1 : ce0;
  assign busy_o    = sel ? busy1 : busy0;
  assign in_ready  = sel ? if1.in_ready : if0.in_ready;
  assign out_valid = sel ? if1.out_valid : if0.out_valid;
  assign obs_cnt   = sel ? {14'd0, cnt1} : cnt0;

  ctl_t obs;
  assign obs = {ctl, busy_o, out_valid};

  // behavioural datapath_mul
  logic signed [15:0] ar, ai, br, bi;
  logic signed [31:0] pp1, pp2, pr, pi;
  always @(posedge clk) begin
    if (ctl[4]) pp1 <= (ctl[6] ? ai : ar) * (ctl[5] ? bi : br);
    if (ctl[3]) pp2 <= (ctl[6] ? ai : ar) * (ctl[5] ? bi : br);
    if (ctl[1]) pr  <= ctl[2] ? pp1 - pp2 : pp1 + pp2;
    if (ctl[0]) pi  <= ctl[2] ? pp1 - pp2 : pp1 + pp2;
  end

  int   n_chk = 0;
  int   n_fail = 0;
  int   cnt_exp = 0;
  ctl_t exp_seq [2][6];
  vec_t vecs [3];

  function automatic logic [31:0] ref_pr(
    input logic signed [15:0] xr, xi, yr, yi, input bit cj);
    longint rr = longint'(xr) * longint'(yr);
    longint ii = longint'(xi) * longint'(yi);
    return 32'(cj ? rr + ii : rr - ii);
  endfunction

  function automatic logic [31:0] ref_pi(
    input logic signed [15:0] xr, xi, yr, yi, input bit cj);
    longint ri = longint'(xr) * longint'(yi);
    longint ir = longint'(xi) * longint'(yr);
    return 32'(cj ? ir - ri : ri + ir);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cmask();
    return sel ? 32'd3 : 32'hFFFF;
  endfunction

  task automatic set_ops(input logic [15:0] xr, xi, yr, yi);
    ar = xr; ai = xi; br = yr; bi = yi;
  endtask

  // checks the six post-accept samples (RR..SUM_I, DONE)
  task automatic sched(input bit cj,
                       input logic [31:0] epr, epi);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      chk($sformatf("ctl_cf%0d_s%0d", cj, k),
          32'(obs), 32'(exp_seq[cj][k]));
    end
    chk("p_r", pr, epr);
    chk("p_i", pi, epi);
  endtask

  task automatic start(input logic [15:0] xr, xi, yr, yi,
                       input bit cj,
                       input logic [31:0] epr, epi);
    set_ops(xr, xi, yr, yi);
    in_valid = 1'b1;
    conj_b   = cj;
    for (int w = 0; w < 20 && !in_ready; w++) tick();
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready %b expected 1",
               in_ready);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    conj_b   = ~cj;
    sched(cj, epr, epi);
  endtask

  task automatic finish(input int stall,
                        input logic [31:0] epr, epi);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_pr", pr, epr);
      chk("hold_pi", pi, epi);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cnt_exp++;
    chk("op_count", 32'(obs_cnt), 32'(cnt_exp) & cmask());
    chk("post_ov", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] xr, xi, yr, yi;
    bit          cj;
    exp_seq[0][0] = 9'b001000010;
    exp_seq[0][1] = 9'b110100010;
    exp_seq[0][2] = 9'b011011010;
    exp_seq[0][3] = 9'b100100010;
    exp_seq[0][4] = 9'b000000110;
    exp_seq[0][5] = 9'b000000001;
    exp_seq[1][0] = 9'b001000010;
    exp_seq[1][1] = 9'b110100010;
    exp_seq[1][2] = 9'b101001010;
    exp_seq[1][3] = 9'b010100010;
    exp_seq[1][4] = 9'b000010110;
    exp_seq[1][5] = 9'b000000001;
    vecs[0] = '{16'h1800, 16'h2000, 16'h0800, 16'hF000,
                1'b0, 32'h02C00000, 32'hFF800000};
    vecs[1] = '{16'h1800, 16'h2000, 16'h0800, 16'hF000,
                1'b1, 32'hFEC00000, 32'h02800000};
    vecs[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000,
                1'b0, 32'h00000000, 32'h80000000};

    in_valid  = 1'b0;
    conj_b    = 1'b0;
    out_ready = 1'b0;
    set_ops(16'h0, 16'h0, 16'h0, 16'h0);
    sel   = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 3; i++) begin
      chk("rst_ctl", 32'(obs), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_cnt", 32'(obs_cnt), 32'd0);
      tick();
    end

    // directed vectors
    foreach (vecs[i]) begin
      start(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi,
            vecs[i].cj, vecs[i].epr, vecs[i].epi);
      finish(0, vecs[i].epr, vecs[i].epi);
    end

    // back-pressure then back-to-back accept
    start(vecs[0].ar, vecs[0].ai, vecs[0].br, vecs[0].bi,
          1'b0, vecs[0].epr, vecs[0].epi);
    set_ops(vecs[1].ar, vecs[1].ai, vecs[1].br, vecs[1].bi);
    in_valid = 1'b1;
    conj_b   = 1'b1;
    for (int s = 0; s < 10; s++) begin
      tick();
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_pr", pr, vecs[0].epr);
      chk("bp_pi", pi, vecs[0].epi);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    conj_b    = 1'b0;
    cnt_exp++;
    chk("b2b_cnt", 32'(obs_cnt), 32'(cnt_exp) & cmask());
    sched(1'b1, vecs[1].epr, vecs[1].epi);
    finish(1, vecs[1].epr, vecs[1].epi);

    // reset during MUL_X1
    set_ops(16'h1234, 16'h4321, 16'h0F0F, 16'hF0F0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("x1_ctl", 32'(obs), 32'(exp_seq[0][2]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt_exp = 0;
    chk("abort_ctl", 32'(obs), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_cnt", 32'(obs_cnt), 32'd0);

    // randomized operations against complex arithmetic
    for (int n = 0; n < 25; n++) begin
      xr = 16'($urandom);
      xi = 16'($urandom);
      yr = 16'($urandom);
      yi = 16'($urandom);
      cj = 1'($urandom);
      start(xr, xi, yr, yi, cj,
            ref_pr(xr, xi, yr, yi, cj),
            ref_pi(xr, xi, yr, yi, cj));
      finish(int'($urandom_range(0, 3)),
             ref_pr(xr, xi, yr, yi, cj),
             ref_pi(xr, xi, yr, yi, cj));
    end

    // second controller: no back-to-back, 2-bit counter
    reset = 1'b1;
    sel   = 1'b1;
    tick();
    reset   = 1'b0;
    cnt_exp = 0;
    chk("r1_ctl", 32'(obs), 32'd0);
    start(vecs[0].ar, vecs[0].ai, vecs[0].br, vecs[0].bi,
          1'b0, vecs[0].epr, vecs[0].epi);
    set_ops(vecs[1].ar, vecs[1].ai, vecs[1].br, vecs[1].bi);
    in_valid = 1'b1;
    conj_b   = 1'b1;
    tick();
    out_ready = 1'b1;
    #1;
    chk("nb2b_in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    cnt_exp++;
    chk("nb2b_cnt", 32'(obs_cnt), 32'(cnt_exp) & cmask());
    chk("nb2b_idle_ctl", 32'(obs), 32'd0);
    chk("nb2b_idle_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    conj_b   = 1'b0;
    sched(1'b1, vecs[1].epr, vecs[1].epi);
    finish(0, vecs[1].epr, vecs[1].epi);
    for (int n = 0; n < 3; n++) begin
      start(vecs[n].ar, vecs[n].ai, vecs[n].br, vecs[n].bi,
            vecs[n].cj, vecs[n].epr, vecs[n].epi);
      finish(n, vecs[n].epr, vecs[n].epi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmul_ctrl.md
Name: cmul_ctrl

Overview:
- FSM controller that drives the control inputs of the complex-multiplier datapath (datapath_mul) through one multiply per operation.
- Runs the 2-partial-product, 5-step schedule that yields p_r and p_i.
- Upstream side uses a valid/ready accept handshake; downstream side uses a valid/ready result handshake.
- Optional conjugate mode computes a*conj(b) on the same datapath.

Parameters:
- CNT_W, 16, width of the completed-operation counter.
- ALLOW_B2B, 1, when 1 a new operation may be accepted in the same cycle the result is consumed.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a_r/a_i/b_r/b_i on the datapath are valid.
- in_ready  output  1  controller can accept an operation.
- conj_b  input  1  sampled at accept; 1 selects a*conj(b).
- out_valid  output  1  p_r/p_i on the datapath hold a finished result.
- out_ready  input  1  downstream consumes the result.
- a_sel  output  1  datapath a select (0 = a_r, 1 = a_i).
- b_sel  output  1  datapath b select (0 = b_r, 1 = b_i).
- pp1_ce  output  1  load pp1.
- pp2_ce  output  1  load pp2.
- sub  output  1  sum = pp1 - pp2 when 1, pp1 + pp2 when 0.
- p_r_ce  output  1  load p_r.
- p_i_ce  output  1  load p_i.
- busy  output  1  high in any state other than IDLE and DONE.
- op_count  output  CNT_W  number of completed result handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset:
  - state = IDLE; conj flag = 0; op_count = 0.
  - All control outputs, out_valid and busy are 0; in_ready = 1.
  - Reset mid-operation aborts immediately. Datapath registers are not cleared.
- States: IDLE, MUL_RR, MUL_II, MUL_X1, MUL_X2, SUM_I, DONE. Each non-IDLE/DONE state lasts exactly 1 cycle.
- Control outputs are Moore decodes of the state register and the captured conj flag (cf). In any state not listed below, a cell is 0.
  - MUL_RR: a_sel=0, b_sel=0, pp1_ce=1. Result: pp1 <= a_r*b_r.
  - MUL_II: a_sel=1, b_sel=1, pp2_ce=1. Result: pp2 <= a_i*b_i.
  - MUL_X1: sub = !cf, p_r_ce=1, pp1_ce=1, with a_sel = cf, b_sel = !cf.
    - cf=0: pp1 <= a_r*b_i.
    - cf=1: pp1 <= a_i*b_r.
    - p_r captures the old pp1 ± pp2 on this same edge.
  - MUL_X2: pp2_ce=1, with a_sel = !cf, b_sel = cf.
    - cf=0: pp2 <= a_i*b_r.
    - cf=1: pp2 <= a_r*b_i.
  - SUM_I: sub = cf, p_i_ce=1.
- Resulting arithmetic:
  - cf=0: p_r = ar*br - ai*bi; p_i = ar*bi + ai*br.
  - cf=1: p_r = ar*br + ai*bi; p_i = ai*br - ar*bi.
- Accept:
  - in_ready = (state==IDLE), OR (ALLOW_B2B && state==DONE && out_ready).
  - in_valid && in_ready at an edge: cf <= conj_b, state -> MUL_RR.
  - in_valid while in_ready=0 is ignored and stays pending.
- Operand stability: upstream holds a_*/b_* stable from the accept edge through the end of MUL_X2 (4 cycles). conj_b is don't-care after accept.
- Latency: out_valid rises 5 cycles after the accept edge (SUM_I -> DONE).
- DONE:
  - out_valid=1; p_r/p_i hold because all ce signals are 0.
  - out_ready=1: op_count increments and state -> IDLE, or -> MUL_RR if a simultaneous accept occurs (ALLOW_B2B=1).
  - out_ready=0: stay in DONE indefinitely.
- Throughput: 1 result per 6 cycles with ALLOW_B2B=1; 1 per 7 cycles with ALLOW_B2B=0.
- op_count wraps from all-ones to 0 with no flag.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Reset then idle: all ce outputs stay 0; in_ready=1; out_valid=0; op_count=0.
- Normal multiply with cmul_ctrl wired to datapath_mul:
  - Inputs: a = 0x1800 + j0x2000 (1.5+2.0j), b = 0x0800 + j0xF000 (0.5-1.0j), conj_b=0.
  - Required: out_valid exactly 5 cycles after accept; p_r=0x02C00000 (2.75); p_i=0xFF800000 (-0.5).
  - Control sequence matches the state list cycle by cycle.
- Same operands, conj_b=1 -> p_r=0xFEC00000 (-1.25), p_i=0x02800000 (2.5); a_sel/b_sel in MUL_X1 = 1/0 and in MUL_X2 = 0/1.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 10 cycles -> out_valid stays 1, p_r/p_i unchanged, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> op_count+1 and MUL_RR on the next cycle (ALLOW_B2B=1).
  - With ALLOW_B2B=0, one IDLE cycle occurs before MUL_RR.
- Reset asserted during MUL_X1 -> next cycle IDLE, all ce outputs 0, out_valid=0, op_count=0.
- With CNT_W=2, complete 5 operations -> op_count sequence 1,2,3,0,1.
